// File: rtl/ysyx_201979054_imm_pkg.sv
// Shared types and constants for the registered immediate generator.
// Format codes match the out_fmt encoding seen by the execute operand mux.
package ysyx_201979054_imm_pkg;

    localparam int XLEN_DEFAULT  = 64;
    localparam int FMT_W_DEFAULT = 3;

    typedef enum logic [2:0] {
        FMT_I    = 3'b000,
        FMT_S    = 3'b001,
        FMT_B    = 3'b010,
        FMT_J    = 3'b011,
        FMT_U    = 3'b100,
        FMT_CSR  = 3'b101,
        FMT_NONE = 3'b110,
        FMT_ILL  = 3'b111
    } imm_fmt_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/ysyx_201979054_imm_decode.sv
// Combinational classify-and-extend: raw instruction -> immediate, format, illegal flag.
// IMM_GEN_ZICSR_EN enables CSR/zimm decoding of SYSTEM; otherwise SYSTEM is R/none.
module ysyx_201979054_imm_decode
    import ysyx_201979054_imm_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_t        o_fmt,
    output logic            o_illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]      w_opcode;
    imm_fmt_t        w_fmt;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_csr;
    logic [XLEN-1:0] w_imm;

    assign w_opcode = i_instr[6:0];

    // Signed casts to XLEN sign-extend from instr[31] for both XLEN choices.
    assign w_imm_i   = XLEN'($signed(i_instr[31:20]));
    assign w_imm_s   = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
    assign w_imm_b   = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
    assign w_imm_j   = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
    assign w_imm_u   = XLEN'($signed({i_instr[31:12], 12'b0}));
    assign w_imm_csr = XLEN'(i_instr[19:15]);

    always_comb begin
        w_fmt = FMT_ILL;
        case (w_opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: w_fmt = FMT_I;
            OPC_OP_IMM32: w_fmt = RV64 ? FMT_I : FMT_ILL;
            OPC_STORE:    w_fmt = FMT_S;
            OPC_BRANCH:   w_fmt = FMT_B;
            OPC_JAL:      w_fmt = FMT_J;
            OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
            OPC_OP:       w_fmt = FMT_NONE;
            OPC_OP32:     w_fmt = RV64 ? FMT_NONE : FMT_ILL;
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                if (i_instr[14]) begin
                    w_fmt = FMT_CSR;
                end else if (i_instr[13:12] != 2'b00) begin
                    w_fmt = FMT_I;
                end else begin
                    w_fmt = FMT_NONE;
                end
`else
                w_fmt = FMT_NONE;
`endif
            end
            default: w_fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        w_imm = '0;
        case (w_fmt)
            FMT_I:   w_imm = w_imm_i;
            FMT_S:   w_imm = w_imm_s;
            FMT_B:   w_imm = w_imm_b;
            FMT_J:   w_imm = w_imm_j;
            FMT_U:   w_imm = w_imm_u;
            FMT_CSR: w_imm = w_imm_csr;
            default: w_imm = '0;
        endcase
    end

    assign o_imm     = w_imm;
    assign o_fmt     = w_fmt;
    assign o_illegal = (w_fmt == FMT_ILL);

endmodule

// File: rtl/ysyx_201979054_imm_gen_pipe.sv
// Registered immediate generator: decode unit followed by a one-entry valid/ready register with flush.
// Optional macro IMM_GEN_ZICSR_EN (handled in the decode unit) enables CSR immediates.
module ysyx_201979054_imm_gen_pipe
    import ysyx_201979054_imm_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int FMT_W = FMT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt,
    output logic             out_illegal
);

    logic [XLEN-1:0] w_imm;
    imm_fmt_t        w_fmt;
    logic            w_illegal;
    logic            w_capture;

    logic            r_valid;
    logic [XLEN-1:0] r_imm;
    imm_fmt_t        r_fmt;
    logic            r_illegal;

    ysyx_201979054_imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_instr   (in_instr),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready;

    // Flush wins over capture; a drain alone only clears valid and leaves the data regs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_valid   <= 1'b0;
            r_imm     <= '0;
            r_fmt     <= FMT_NONE;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid   <= 1'b0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_imm     <= w_imm;
            r_fmt     <= w_fmt;
            r_illegal <= w_illegal;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_imm     = r_imm;
    assign out_fmt     = FMT_W'(r_fmt);
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_ysyx_201979054_imm_gen_pipe.sv
// Self-checking bench: vector table + scoreboard for the XLEN=64 pipe, plus a short XLEN=32 sequence.
module tb_ysyx_201979054_imm_gen_pipe;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    localparam int NV = 19;

    logic        clk;
    logic        arst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    logic        v32_in_valid;
    logic        v32_in_ready;
    logic [31:0] v32_in_instr;
    logic        v32_out_valid;
    logic [31:0] v32_out_imm;
    logic [2:0]  v32_out_fmt;
    logic        v32_out_illegal;

    vec_t tbl [NV];
    vec_t sb  [$];
    int   n_cmp;
    int   n_bad;

    ysyx_201979054_imm_gen_pipe #(.XLEN(64), .FMT_W(3)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal)
    );

    ysyx_201979054_imm_gen_pipe #(.XLEN(32), .FMT_W(3)) dut32 (
        .clk         (clk),
        .arst_n      (arst_n),
        .in_valid    (v32_in_valid),
        .in_ready    (v32_in_ready),
        .in_instr    (v32_in_instr),
        .flush       (1'b0),
        .out_valid   (v32_out_valid),
        .out_ready   (1'b1),
        .out_imm     (v32_out_imm),
        .out_fmt     (v32_out_fmt),
        .out_illegal (v32_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output side of the scoreboard: held outputs are compared every cycle, popped when consumed or flushed.
    always @(negedge clk) begin
        vec_t e;
        if (arst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got out_valid=1 imm %h required no output", out_imm);
            end else begin
                e = sb[0];
                chk("sb_imm", out_imm, e.imm);
                chk("sb_fmt", 64'(out_fmt), 64'(e.fmt));
                chk("sb_ill", 64'(out_illegal), 64'(e.ill));
                if (out_ready || flush) e = sb.pop_front();
            end
        end
    end

    task automatic cycle(input logic v, input vec_t e, input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = e.instr;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        if (v && in_ready && !fl) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step32(input logic [31:0] instr, input logic [31:0] imm, input logic [2:0] fmt,
                          input logic ill);
        v32_in_valid = 1'b1;
        v32_in_instr = instr;
        @(posedge clk);
        #1;
        chk("x32_valid", 64'(v32_out_valid), 64'd1);
        chk("x32_imm", 64'(v32_out_imm), 64'(imm));
        chk("x32_fmt", 64'(v32_out_fmt), 64'(fmt));
        chk("x32_ill", 64'(v32_out_illegal), 64'(ill));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tbl[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0};
        tbl[1]  = '{32'hFE20AE23, 64'hFFFF_FFFF_FFFF_FFFC, 3'b001, 1'b0};
        tbl[2]  = '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'b011, 1'b0};
        tbl[3]  = '{32'h123450B7, 64'h0000_0000_1234_5000, 3'b100, 1'b0};
        tbl[4]  = '{32'h0000007F, 64'h0,                   3'b111, 1'b1};
        tbl[5]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'b010, 1'b0};
        tbl[6]  = '{32'h00000463, 64'h8,                   3'b010, 1'b0};
        tbl[7]  = '{32'h002081B3, 64'h0,                   3'b110, 1'b0};
        tbl[8]  = '{32'h80000017, 64'hFFFF_FFFF_8000_0000, 3'b100, 1'b0};
        tbl[9]  = '{32'h0010809B, 64'h1,                   3'b000, 1'b0};
        tbl[10] = '{32'h0000101B, 64'h0,                   3'b000, 1'b0};
        tbl[11] = '{32'h001000EF, 64'h800,                 3'b011, 1'b0};
        tbl[12] = '{32'h7FF12083, 64'h7FF,                 3'b000, 1'b0};
        tbl[13] = '{32'h12345057, 64'h0,                   3'b111, 1'b1};
`ifdef IMM_GEN_ZICSR_EN
        tbl[14] = '{32'h3002D073, 64'h5,                   3'b101, 1'b0};
        tbl[15] = '{32'h30029073, 64'h300,                 3'b000, 1'b0};
`else
        tbl[14] = '{32'h3002D073, 64'h0,                   3'b110, 1'b0};
        tbl[15] = '{32'h30029073, 64'h0,                   3'b110, 1'b0};
`endif
        tbl[16] = '{32'h00000073, 64'h0,                   3'b110, 1'b0};
        tbl[17] = '{32'h0FF0000F, 64'hFF,                  3'b000, 1'b0};
        tbl[18] = '{32'h80008067, 64'hFFFF_FFFF_FFFF_F800, 3'b000, 1'b0};

        arst_n       = 1'b0;
        in_valid     = 1'b0;
        in_instr     = 32'h0;
        flush        = 1'b0;
        out_ready    = 1'b1;
        v32_in_valid = 1'b0;
        v32_in_instr = 32'h0;
        #23;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", out_imm, 64'd0);
        chk("rst_fmt", 64'(out_fmt), 64'd6);
        chk("rst_ill", 64'(out_illegal), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: nothing visible before the capturing edge, result right after it.
        in_valid = 1'b1;
        in_instr = tbl[0].instr;
        #1;
        chk("lat_pre_valid", 64'(out_valid), 64'd0);
        cycle(1'b1, tbl[0], 1'b1, 1'b0);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_imm", out_imm, tbl[0].imm);
        cycle(1'b0, tbl[0], 1'b1, 1'b0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Back-to-back stream of the whole table.
        for (int i = 0; i < NV; i++) begin
            cycle(1'b1, tbl[i], 1'b1, 1'b0);
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
        end
        cycle(1'b0, tbl[0], 1'b1, 1'b0);
        chk("stream_drain", 64'(out_valid), 64'd0);

        // Backpressure: hold for 3 cycles while the instruction changes.
        cycle(1'b1, tbl[3], 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, tbl[k], 1'b0, 1'b0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_imm_frozen", out_imm, tbl[3].imm);
            chk("bp_fmt_frozen", 64'(out_fmt), 64'(tbl[3].fmt));
        end
        cycle(1'b1, tbl[4], 1'b1, 1'b0);
        chk("bp_next_imm", out_imm, tbl[4].imm);
        chk("bp_next_ill", 64'(out_illegal), 64'd1);
        cycle(1'b0, tbl[0], 1'b1, 1'b0);

        // Flush against a held result with a capture attempt, then against an empty stage.
        cycle(1'b1, tbl[8], 1'b0, 1'b0);
        cycle(1'b1, tbl[9], 1'b0, 1'b1);
        chk("flush_held_valid", 64'(out_valid), 64'd0);
        chk("flush_sb_empty", 64'(sb.size()), 64'd0);
        cycle(1'b1, tbl[11], 1'b1, 1'b1);
        chk("flush_empty_valid", 64'(out_valid), 64'd0);
        cycle(1'b1, tbl[11], 1'b1, 1'b0);
        chk("post_flush_imm", out_imm, tbl[11].imm);

        // Asynchronous reset in the middle of a held transfer.
        cycle(1'b1, tbl[2], 1'b0, 1'b0);
        in_valid = 1'b0;
        arst_n   = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_imm", out_imm, 64'd0);
        chk("arst_fmt", 64'(out_fmt), 64'd6);
        sb.delete();
        @(negedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random valid/ready traffic over the table.
        for (int n = 0; n < 60; n++) begin
            int idx;
            idx = int'($urandom_range(0, NV - 1));
            cycle(1'($urandom_range(0, 1)), tbl[idx], 1'($urandom_range(0, 1)), 1'b0);
        end
        cycle(1'b0, tbl[0], 1'b1, 1'b0);
        cycle(1'b0, tbl[0], 1'b1, 1'b0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("final_valid", 64'(out_valid), 64'd0);

        // XLEN=32 instance: OP-IMM-32 is illegal, sign extension stops at bit 31.
        step32(32'h0000101B, 32'h0, 3'b111, 1'b1);
        step32(32'hFFF00093, 32'hFFFF_FFFF, 3'b000, 1'b0);
        step32(32'h80000017, 32'h8000_0000, 3'b100, 1'b0);
        step32(32'h0000003B, 32'h0, 3'b111, 1'b1);
        v32_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("x32_drain", 64'(v32_out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
